// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: point detection, score keeping, serve delay and winner.
// Optional build macro PONG_AUTO_RESTART_EN adds a timed return from GAME_OVER to START.
module pong_match_ctrl #(
    parameter int WIN_SCORE     = 5,
    parameter int SERVE_TICKS   = 60,
    parameter int LEFT_OUT      = 8,
    parameter int RIGHT_OUT     = 1001
`ifdef PONG_AUTO_RESTART_EN
    ,
    parameter int RESTART_TICKS = 300
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        start_btn,
    input  logic [10:0] x_ball,
    output logic [1:0]  state,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        winner,
    output logic [6:0]  serve_cnt
);

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_POINT = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    // A zero serve delay still spends one tick in POINT.
    localparam logic [6:0]  SERVE_LOAD = (SERVE_TICKS == 0) ? 7'd1 : 7'(SERVE_TICKS);
    localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [10:0] LEFT_LIM   = 11'(LEFT_OUT);
    localparam logic [10:0] RIGHT_LIM  = 11'(RIGHT_OUT);
`ifdef PONG_AUTO_RESTART_EN
    localparam logic [8:0]  RESTART_LOAD = 9'(RESTART_TICKS);
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v == 4'd15) begin
            return v;
        end else begin
            return v + 4'd1;
        end
    endfunction

    state_e     state_q, state_d;
    logic [3:0] score_left_q, score_left_d;
    logic [3:0] score_right_q, score_right_d;
    logic       winner_q, winner_d;
    logic [6:0] serve_cnt_q, serve_cnt_d;
    logic       start_btn_q;
    logic       start_rise_q;
`ifdef PONG_AUTO_RESTART_EN
    logic [8:0] restart_cnt_q, restart_cnt_d;
`endif

    // Button edge detector; the delay flop resets high so a held button is not a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_btn_q  <= 1'b1;
            start_rise_q <= 1'b0;
        end else begin
            start_btn_q  <= start_btn;
            start_rise_q <= start_btn & ~start_btn_q;
        end
    end

    // Match state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_START;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            winner_q      <= 1'b0;
            serve_cnt_q   <= 7'd0;
`ifdef PONG_AUTO_RESTART_EN
            restart_cnt_q <= 9'd0;
`endif
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
            serve_cnt_q   <= serve_cnt_d;
`ifdef PONG_AUTO_RESTART_EN
            restart_cnt_q <= restart_cnt_d;
`endif
        end
    end

    // Next-state and next-output decisions.
    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        winner_d      = winner_q;
        serve_cnt_d   = serve_cnt_q;
`ifdef PONG_AUTO_RESTART_EN
        restart_cnt_d = restart_cnt_q;
`endif
        case (state_q)
            ST_START: begin
                if (start_rise_q) begin
                    score_left_d  = 4'd0;
                    score_right_d = 4'd0;
                    winner_d      = 1'b0;
                    state_d       = ST_PLAY;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_PLAY: begin
                // Leaving PLAY recentres the ball, so only one point counts per exit.
                if (x_ball <= LEFT_LIM) begin
                    score_right_d = sat_inc(score_right_q);
                    serve_cnt_d   = SERVE_LOAD;
                    state_d       = ST_POINT;
                end else if (x_ball >= RIGHT_LIM) begin
                    score_left_d = sat_inc(score_left_q);
                    serve_cnt_d  = SERVE_LOAD;
                    state_d      = ST_POINT;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_POINT: begin
                if ((score_left_q == WIN_VAL) || (score_right_q == WIN_VAL)) begin
                    winner_d    = (score_right_q == WIN_VAL);
                    serve_cnt_d = 7'd0;
                    state_d     = ST_OVER;
`ifdef PONG_AUTO_RESTART_EN
                    restart_cnt_d = RESTART_LOAD;
`endif
                end else if (timing_tick) begin
                    if (serve_cnt_q <= 7'd1) begin
                        serve_cnt_d = 7'd0;
                        state_d     = ST_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q - 7'd1;
                    end
                end else begin
                    state_d = ST_POINT;
                end
            end
            ST_OVER: begin
`ifdef PONG_AUTO_RESTART_EN
                if (start_rise_q) begin
                    restart_cnt_d = 9'd0;
                    state_d       = ST_START;
                end else if (timing_tick) begin
                    if (restart_cnt_q <= 9'd1) begin
                        restart_cnt_d = 9'd0;
                        state_d       = ST_START;
                    end else begin
                        restart_cnt_d = restart_cnt_q - 9'd1;
                    end
                end else begin
                    state_d = ST_OVER;
                end
`else
                if (start_rise_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_OVER;
                end
`endif
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    assign state       = state_q;
    assign score_left  = score_left_q;
    assign score_right = score_right_q;
    assign winner      = winner_q;
    assign serve_cnt   = serve_cnt_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl with WIN_SCORE=5, SERVE_TICKS=3, RESTART_TICKS=4.
module tb_pong_match_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        timing_tick;
    logic        start_btn;
    logic [10:0] x_ball;
    logic [1:0]  state;
    logic [3:0]  score_left;
    logic [3:0]  score_right;
    logic        winner;
    logic [6:0]  serve_cnt;
    logic [17:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        r;
        logic        b;
        logic        t;
        logic [10:0] x;
        logic [17:0] e;
    } step_t;

    step_t sb[$];

    pong_match_ctrl #(
        .WIN_SCORE(5),
        .SERVE_TICKS(3),
        .LEFT_OUT(8),
        .RIGHT_OUT(1001)
`ifdef PONG_AUTO_RESTART_EN
        ,
        .RESTART_TICKS(4)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .timing_tick(timing_tick),
        .start_btn(start_btn),
        .x_ball(x_ball),
        .state(state),
        .score_left(score_left),
        .score_right(score_right),
        .winner(winner),
        .serve_cnt(serve_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {state, score_left, score_right, winner, serve_cnt};

    // Queue one cycle of stimulus with the outputs expected after that edge.
    task automatic add(input logic r, input logic b, input logic t, input int x,
                       input int st, input int sl, input int sr, input int w, input int sc);
        step_t s;
        s.r = r;
        s.b = b;
        s.t = t;
        s.x = 11'(x);
        s.e = {2'(st), 4'(sl), 4'(sr), 1'(w), 7'(sc)};
        sb.push_back(s);
    endtask

    task automatic test_reset();
        step_t s;
        int i = 0;
        add(1, 1, 0, 500, 0, 0, 0, 0, 0);
        add(1, 1, 0, 500, 0, 0, 0, 0, 0);
        add(0, 1, 0, 500, 0, 0, 0, 0, 0);
        add(0, 1, 0, 500, 0, 0, 0, 0, 0);
        add(0, 0, 0, 500, 0, 0, 0, 0, 0);
        add(0, 0, 0, 500, 0, 0, 0, 0, 0);
        add(0, 1, 0, 500, 0, 0, 0, 0, 0);
        add(0, 1, 0, 500, 1, 0, 0, 0, 0);
        add(0, 1, 0, 500, 1, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; start_btn = s.b; timing_tick = s.t; x_ball = s.x;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== s.e) begin
                n_fail++;
                $display("FAIL reset step %0d: {st,L,R,win,serve} got %h required %h", i, obs, s.e);
            end
            i++;
        end
    endtask

    task automatic test_point_and_serve();
        step_t s;
        int i = 0;
        // Ball held out after scoring: only one point counted.
        add(0, 1, 0, 8, 2, 0, 1, 0, 3);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 8, 2, 0, 1, 0, 3);
        // Serve countdown; button press inside POINT is ignored.
        add(0, 1, 1, 500, 2, 0, 1, 0, 2);
        add(0, 0, 0, 500, 2, 0, 1, 0, 2);
        add(0, 1, 0, 500, 2, 0, 1, 0, 2);
        add(0, 1, 1, 500, 2, 0, 1, 0, 1);
        add(0, 1, 1, 500, 1, 0, 1, 0, 0);
        add(0, 1, 0, 500, 1, 0, 1, 0, 0);
        // Tick in the same cycle as POINT entry does not decrement.
        add(0, 1, 1, 1001, 2, 1, 1, 0, 3);
        add(0, 1, 1, 500, 2, 1, 1, 0, 2);
        add(0, 1, 1, 500, 2, 1, 1, 0, 1);
        add(0, 1, 1, 500, 1, 1, 1, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; start_btn = s.b; timing_tick = s.t; x_ball = s.x;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== s.e) begin
                n_fail++;
                $display("FAIL point_serve step %0d: {st,L,R,win,serve} got %h required %h", i, obs, s.e);
            end
            i++;
        end
    endtask

    task automatic test_win_left();
        step_t s;
        int i = 0;
        for (int k = 2; k <= 4; k++) begin
            add(0, 1, 0, 1001, 2, k, 1, 0, 3);
            add(0, 1, 1, 500, 2, k, 1, 0, 2);
            add(0, 1, 1, 500, 2, k, 1, 0, 1);
            add(0, 1, 1, 500, 1, k, 1, 0, 0);
        end
        add(0, 1, 0, 1001, 2, 5, 1, 0, 3);
        add(0, 1, 0, 500, 3, 5, 1, 0, 0);
        add(0, 1, 0, 500, 3, 5, 1, 0, 0);
        // start_rise to START keeps scores; next start_rise clears them.
        add(0, 0, 0, 500, 3, 5, 1, 0, 0);
        add(0, 1, 0, 500, 3, 5, 1, 0, 0);
        add(0, 1, 0, 500, 0, 5, 1, 0, 0);
        add(0, 1, 0, 500, 0, 5, 1, 0, 0);
        add(0, 0, 0, 500, 0, 5, 1, 0, 0);
        add(0, 1, 0, 500, 0, 5, 1, 0, 0);
        add(0, 1, 0, 500, 1, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; start_btn = s.b; timing_tick = s.t; x_ball = s.x;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== s.e) begin
                n_fail++;
                $display("FAIL win_left step %0d: {st,L,R,win,serve} got %h required %h", i, obs, s.e);
            end
            i++;
        end
    endtask

    task automatic test_win_right();
        step_t s;
        int i = 0;
        for (int k = 1; k <= 4; k++) begin
            add(0, 1, 0, 8, 2, 0, k, 0, 3);
            add(0, 1, 1, 500, 2, 0, k, 0, 2);
            add(0, 1, 1, 500, 2, 0, k, 0, 1);
            add(0, 1, 1, 500, 1, 0, k, 0, 0);
        end
        add(0, 1, 0, 8, 2, 0, 5, 0, 3);
        add(0, 1, 0, 500, 3, 0, 5, 1, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; start_btn = s.b; timing_tick = s.t; x_ball = s.x;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== s.e) begin
                n_fail++;
                $display("FAIL win_right step %0d: {st,L,R,win,serve} got %h required %h", i, obs, s.e);
            end
            i++;
        end
    endtask

    task automatic test_game_over_exit();
        step_t s;
        int i = 0;
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 1, 500, 3, 0, 5, 1, 0);
            add(0, 1, 0, 500, 3, 0, 5, 1, 0);
        end
`ifdef PONG_AUTO_RESTART_EN
        add(0, 1, 1, 500, 0, 0, 5, 1, 0);
        add(0, 1, 0, 500, 0, 0, 5, 1, 0);
`else
        add(0, 1, 1, 500, 3, 0, 5, 1, 0);
        add(0, 1, 1, 500, 3, 0, 5, 1, 0);
        add(0, 0, 0, 500, 3, 0, 5, 1, 0);
        add(0, 1, 0, 500, 3, 0, 5, 1, 0);
        add(0, 1, 0, 500, 0, 0, 5, 1, 0);
`endif
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; start_btn = s.b; timing_tick = s.t; x_ball = s.x;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== s.e) begin
                n_fail++;
                $display("FAIL game_over_exit step %0d: {st,L,R,win,serve} got %h required %h", i, obs, s.e);
            end
            i++;
        end
    endtask

    task automatic test_mid_reset();
        step_t s;
        int i = 0;
        add(0, 0, 0, 500, 0, 0, 5, 1, 0);
        add(0, 1, 0, 500, 0, 0, 5, 1, 0);
        add(0, 1, 0, 500, 1, 0, 0, 0, 0);
        add(0, 1, 0, 8, 2, 0, 1, 0, 3);
        add(0, 1, 1, 500, 2, 0, 1, 0, 2);
        add(1, 1, 0, 500, 0, 0, 0, 0, 0);
        add(0, 1, 0, 500, 0, 0, 0, 0, 0);
        add(0, 1, 0, 500, 0, 0, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst = s.r; start_btn = s.b; timing_tick = s.t; x_ball = s.x;
            @(posedge clk); #1;
            n_checks++;
            if (obs !== s.e) begin
                n_fail++;
                $display("FAIL mid_reset step %0d: {st,L,R,win,serve} got %h required %h", i, obs, s.e);
            end
            i++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_btn   = 1'b1;
        timing_tick = 1'b0;
        x_ball      = 11'd500;
        test_reset();
        test_point_and_serve();
        test_win_left();
        test_win_right();
        test_game_over_exit();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
